// File: rtl/xc_rvfi_trace_gen.sv
// xc_rvfi_trace_gen: registers one RVFI trace record per retired instruction, merging late load data.
module xc_rvfi_trace_gen #(
  parameter int XLEN    = 32,
  parameter int ORDER_W = 64
) (
  input  logic               g_clk,
  input  logic               g_resetn,
  input  logic               trs_valid,
  output logic               trs_ready,
  input  logic               trs_flush,
  input  logic [31:0]        trs_insn,
  input  logic [XLEN-1:0]    trs_pc_rdata,
  input  logic [XLEN-1:0]    trs_pc_wdata,
  input  logic               trs_trap,
  input  logic [4:0]         trs_rs1_addr,
  input  logic [4:0]         trs_rs2_addr,
  input  logic [4:0]         trs_rs3_addr,
  input  logic [XLEN-1:0]    trs_rs1_rdata,
  input  logic [XLEN-1:0]    trs_rs2_rdata,
  input  logic [XLEN-1:0]    trs_rs3_rdata,
  input  logic [4:0]         trs_rd_addr,
  input  logic [XLEN-1:0]    trs_rd_wdata,
  input  logic [XLEN-1:0]    trs_rd_wdatahi,
  input  logic               trs_rd_wide,
  input  logic [XLEN-1:0]    trs_mem_addr,
  input  logic [XLEN-1:0]    trs_mem_wdata,
  input  logic [3:0]         trs_mem_rmask,
  input  logic [3:0]         trs_mem_wmask,
  input  logic               trs_mem_pending,
  input  logic               mem_rsp_valid,
  input  logic [XLEN-1:0]    mem_rsp_rdata,
  output logic               rvfi_valid,
  output logic [ORDER_W-1:0] rvfi_order,
  output logic [31:0]        rvfi_insn,
  output logic               rvfi_trap,
  output logic               rvfi_intr,
  output logic               rvfi_halt,
  output logic [4:0]         rvfi_rs1_addr,
  output logic [4:0]         rvfi_rs2_addr,
  output logic [4:0]         rvfi_rs3_addr,
  output logic [XLEN-1:0]    rvfi_rs1_rdata,
  output logic [XLEN-1:0]    rvfi_rs2_rdata,
  output logic [XLEN-1:0]    rvfi_rs3_rdata,
  output logic [4:0]         rvfi_rd_addr,
  output logic [XLEN-1:0]    rvfi_rd_wdata,
  output logic [XLEN-1:0]    rvfi_rd_wdatahi,
  output logic               rvfi_rd_wide,
  output logic [XLEN-1:0]    rvfi_pc_rdata,
  output logic [XLEN-1:0]    rvfi_pc_wdata,
  output logic [XLEN-1:0]    rvfi_mem_addr,
  output logic [XLEN-1:0]    rvfi_mem_rdata,
  output logic [XLEN-1:0]    rvfi_mem_wdata,
  output logic [3:0]         rvfi_mem_rmask,
  output logic [3:0]         rvfi_mem_wmask,
  output logic               trace_err
);
  typedef enum logic {IDLE, HOLD} state_t;
  typedef struct packed {
    logic [31:0]     insn;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic            trap;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rs3_addr;
    logic [XLEN-1:0] rs1_rdata;
    logic [XLEN-1:0] rs2_rdata;
    logic [XLEN-1:0] rs3_rdata;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic [XLEN-1:0] rd_wdatahi;
    logic            rd_wide;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_rmask;
    logic [3:0]      mem_wmask;
  } rec_t;
  state_t state, state_n;
  rec_t in_rec, held, src, out_n, out_rec;
  logic emit, capture, holding;
  logic [ORDER_W-1:0] cnt;
  logic intr_pending;
  assign holding = state == HOLD;
  assign trs_ready = !holding;
  always_comb begin
    in_rec = '{insn: trs_insn, pc_rdata: trs_pc_rdata, pc_wdata: trs_pc_wdata, trap: trs_trap,
               rs1_addr: trs_rs1_addr, rs2_addr: trs_rs2_addr, rs3_addr: trs_rs3_addr,
               rs1_rdata: trs_rs1_rdata, rs2_rdata: trs_rs2_rdata, rs3_rdata: trs_rs3_rdata,
               rd_addr: trs_rd_addr, rd_wdata: trs_rd_wdata, rd_wdatahi: trs_rd_wdatahi,
               rd_wide: trs_rd_wide, mem_addr: trs_mem_addr, mem_wdata: trs_mem_wdata,
               mem_rmask: trs_mem_rmask, mem_wmask: trs_mem_wmask};
    // flush beats both a new retirement and a load response
    emit = !trs_flush && (holding ? mem_rsp_valid : trs_valid && !trs_mem_pending);
    capture = !holding && trs_valid && trs_mem_pending && !trs_flush;
    state_n = capture ? HOLD : (holding && (trs_flush || mem_rsp_valid)) ? IDLE : state;
    src = holding ? held : in_rec;
    if (holding) src.rd_wdata = mem_rsp_rdata;
    out_n = src;
    out_n.rd_wdata = src.rd_addr == 5'd0 ? '0 : src.rd_wdata;
    out_n.rd_wdatahi = (src.rd_addr == 5'd0 || !src.rd_wide) ? '0 : src.rd_wdatahi;
  end
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      held <= '0;
      out_rec <= '0;
      cnt <= '0;
      intr_pending <= 1'b0;
      rvfi_valid <= 1'b0;
      rvfi_order <= '0;
      rvfi_intr <= 1'b0;
      rvfi_mem_rdata <= '0;
      trace_err <= 1'b0;
    end else begin
      rvfi_valid <= emit;
      trace_err <= trace_err || (!holding && mem_rsp_valid) || (holding && trs_valid);
      if (capture) held <= in_rec;
      if (emit) begin
        out_rec <= out_n;
        rvfi_order <= cnt;
        cnt <= cnt + 1'b1;
        rvfi_intr <= intr_pending;
        intr_pending <= src.trap;
        rvfi_mem_rdata <= holding ? mem_rsp_rdata : '0;
      end
    end
  end
  assign rvfi_halt = 1'b0;
  assign rvfi_insn = out_rec.insn;
  assign rvfi_trap = out_rec.trap;
  assign rvfi_rs1_addr = out_rec.rs1_addr;
  assign rvfi_rs2_addr = out_rec.rs2_addr;
  assign rvfi_rs3_addr = out_rec.rs3_addr;
  assign rvfi_rs1_rdata = out_rec.rs1_rdata;
  assign rvfi_rs2_rdata = out_rec.rs2_rdata;
  assign rvfi_rs3_rdata = out_rec.rs3_rdata;
  assign rvfi_rd_addr = out_rec.rd_addr;
  assign rvfi_rd_wdata = out_rec.rd_wdata;
  assign rvfi_rd_wdatahi = out_rec.rd_wdatahi;
  assign rvfi_rd_wide = out_rec.rd_wide;
  assign rvfi_pc_rdata = out_rec.pc_rdata;
  assign rvfi_pc_wdata = out_rec.pc_wdata;
  assign rvfi_mem_addr = out_rec.mem_addr;
  assign rvfi_mem_wdata = out_rec.mem_wdata;
  assign rvfi_mem_rmask = out_rec.mem_rmask;
  assign rvfi_mem_wmask = out_rec.mem_wmask;
endmodule

// File: tb/tb_xc_rvfi_trace_gen.sv
// tb_xc_rvfi_trace_gen: directed vector table, reset-in-HOLD sequence and randomized run against a reference model.
module tb_xc_rvfi_trace_gen;
  logic g_clk = 1'b0, g_resetn = 1'b0;
  logic trs_valid, trs_ready, trs_flush, trs_trap, trs_rd_wide, trs_mem_pending, mem_rsp_valid;
  logic [31:0] trs_insn, trs_pc_rdata, trs_pc_wdata, trs_rs1_rdata, trs_rs2_rdata, trs_rs3_rdata;
  logic [31:0] trs_rd_wdata, trs_rd_wdatahi, trs_mem_addr, trs_mem_wdata, mem_rsp_rdata;
  logic [4:0] trs_rs1_addr, trs_rs2_addr, trs_rs3_addr, trs_rd_addr;
  logic [3:0] trs_mem_rmask, trs_mem_wmask;
  logic rvfi_valid, rvfi_trap, rvfi_intr, rvfi_halt, rvfi_rd_wide, trace_err;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata, rvfi_rd_wdata, rvfi_rd_wdatahi;
  logic [31:0] rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
  logic [4:0] rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr, rvfi_rd_addr;
  logic [3:0] rvfi_mem_rmask, rvfi_mem_wmask;

  always #5 g_clk = ~g_clk;

  xc_rvfi_trace_gen dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .trs_valid(trs_valid), .trs_ready(trs_ready),
    .trs_flush(trs_flush), .trs_insn(trs_insn), .trs_pc_rdata(trs_pc_rdata), .trs_pc_wdata(trs_pc_wdata),
    .trs_trap(trs_trap), .trs_rs1_addr(trs_rs1_addr), .trs_rs2_addr(trs_rs2_addr), .trs_rs3_addr(trs_rs3_addr),
    .trs_rs1_rdata(trs_rs1_rdata), .trs_rs2_rdata(trs_rs2_rdata), .trs_rs3_rdata(trs_rs3_rdata),
    .trs_rd_addr(trs_rd_addr), .trs_rd_wdata(trs_rd_wdata), .trs_rd_wdatahi(trs_rd_wdatahi),
    .trs_rd_wide(trs_rd_wide), .trs_mem_addr(trs_mem_addr), .trs_mem_wdata(trs_mem_wdata),
    .trs_mem_rmask(trs_mem_rmask), .trs_mem_wmask(trs_mem_wmask), .trs_mem_pending(trs_mem_pending),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .rvfi_valid(rvfi_valid),
    .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap), .rvfi_intr(rvfi_intr),
    .rvfi_halt(rvfi_halt), .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
    .rvfi_rs3_addr(rvfi_rs3_addr), .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_rs3_rdata(rvfi_rs3_rdata), .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_rd_wdatahi(rvfi_rd_wdatahi), .rvfi_rd_wide(rvfi_rd_wide), .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rdata(rvfi_mem_rdata),
    .rvfi_mem_wdata(rvfi_mem_wdata), .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .trace_err(trace_err)
  );

  typedef struct packed {
    logic [31:0] insn, pc_r, pc_w;
    logic trap;
    logic [4:0] rs1a, rs2a, rs3a;
    logic [31:0] rs1d, rs2d, rs3d;
    logic [4:0] rda;
    logic [31:0] rdd, rdh;
    logic wide;
    logic [31:0] maddr, mwd;
    logic [3:0] rmask, wmask;
    logic pending;
  } txn_t;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] insn;
    logic trap, intr, halt;
    logic [4:0] rs1a, rs2a, rs3a;
    logic [31:0] rs1d, rs2d, rs3d;
    logic [4:0] rda;
    logic [31:0] rdd, rdh;
    logic wide;
    logic [31:0] pcr, pcw, maddr, mrd, mwd;
    logic [3:0] rmask, wmask;
  } out_t;

  typedef struct {
    txn_t t;
    logic v, fl, rsp;
    logic [31:0] rdata;
    logic e_rdy, e_val;
    logic [63:0] e_ord;
    logic e_intr;
    logic [31:0] e_rdd, e_rdh;
    logic e_err;
  } vec_t;

  out_t dut_o, exp_o;
  assign dut_o = '{order: rvfi_order, insn: rvfi_insn, trap: rvfi_trap, intr: rvfi_intr, halt: rvfi_halt,
                   rs1a: rvfi_rs1_addr, rs2a: rvfi_rs2_addr, rs3a: rvfi_rs3_addr,
                   rs1d: rvfi_rs1_rdata, rs2d: rvfi_rs2_rdata, rs3d: rvfi_rs3_rdata,
                   rda: rvfi_rd_addr, rdd: rvfi_rd_wdata, rdh: rvfi_rd_wdatahi, wide: rvfi_rd_wide,
                   pcr: rvfi_pc_rdata, pcw: rvfi_pc_wdata, maddr: rvfi_mem_addr, mrd: rvfi_mem_rdata,
                   mwd: rvfi_mem_wdata, rmask: rvfi_mem_rmask, wmask: rvfi_mem_wmask};

  int tests = 0, fails = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rec(string name);
    tests++;
    if (dut_o !== exp_o) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, dut_o, exp_o);
    end
  endtask

  // Reference model: a queue holds at most one load awaiting its data.
  txn_t held_q[$];
  longint unsigned m_ord;
  bit m_intr, m_err, m_valid;

  function automatic void model_reset();
    held_q.delete();
    m_ord = 0;
    m_intr = 0;
    m_err = 0;
    m_valid = 0;
    exp_o = '0;
  endfunction

  function automatic void model(txn_t t, logic v, logic fl, logic rsp, logic [31:0] rd);
    txn_t e = '0;
    logic [31:0] md = '0;
    bit emit = 0;
    bit busy = held_q.size() != 0;
    if ((!busy && rsp) || (busy && v)) m_err = 1;
    if (!busy) begin
      if (v && !fl) begin
        if (t.pending) held_q.push_back(t);
        else begin
          emit = 1;
          e = t;
        end
      end
    end else if (fl) held_q.delete();
    else if (rsp) begin
      e = held_q.pop_front();
      e.rdd = rd;
      md = rd;
      emit = 1;
    end
    m_valid = emit;
    if (emit) begin
      exp_o = '{order: m_ord, insn: e.insn, trap: e.trap, intr: m_intr, halt: 1'b0,
                rs1a: e.rs1a, rs2a: e.rs2a, rs3a: e.rs3a, rs1d: e.rs1d, rs2d: e.rs2d, rs3d: e.rs3d,
                rda: e.rda, rdd: e.rda == 0 ? 32'h0 : e.rdd,
                rdh: (e.rda == 0 || !e.wide) ? 32'h0 : e.rdh, wide: e.wide,
                pcr: e.pc_r, pcw: e.pc_w, maddr: e.maddr, mrd: md, mwd: e.mwd,
                rmask: e.rmask, wmask: e.wmask};
      m_ord++;
      m_intr = e.trap;
    end
  endfunction

  task automatic drive(txn_t t, logic v, logic fl, logic rsp, logic [31:0] rd);
    trs_valid = v; trs_flush = fl; trs_insn = t.insn; trs_pc_rdata = t.pc_r; trs_pc_wdata = t.pc_w;
    trs_trap = t.trap; trs_rs1_addr = t.rs1a; trs_rs2_addr = t.rs2a; trs_rs3_addr = t.rs3a;
    trs_rs1_rdata = t.rs1d; trs_rs2_rdata = t.rs2d; trs_rs3_rdata = t.rs3d; trs_rd_addr = t.rda;
    trs_rd_wdata = t.rdd; trs_rd_wdatahi = t.rdh; trs_rd_wide = t.wide; trs_mem_addr = t.maddr;
    trs_mem_wdata = t.mwd; trs_mem_rmask = t.rmask; trs_mem_wmask = t.wmask;
    trs_mem_pending = t.pending; mem_rsp_valid = rsp; mem_rsp_rdata = rd;
  endtask

  task automatic cyc(txn_t t, logic v, logic fl, logic rsp, logic [31:0] rd, output logic rdy);
    @(negedge g_clk);
    drive(t, v, fl, rsp, rd);
    #1 rdy = trs_ready;
    chk("ready", 64'(trs_ready), 64'(held_q.size() == 0));
    model(t, v, fl, rsp, rd);
    @(posedge g_clk);
    #1;
    chk("valid", 64'(rvfi_valid), 64'(m_valid));
    chk("trace_err", 64'(trace_err), 64'(m_err));
    chk_rec("record");
  endtask

  function automatic txn_t mk_txn(logic [31:0] pc, logic [31:0] pcw, logic trap, logic [4:0] rda,
                                  logic [31:0] rdd, logic [31:0] rdh, logic wide, logic pend);
    txn_t t;
    t = '{insn: {pc[23:0], 8'h13}, pc_r: pc, pc_w: pcw, trap: trap, rs1a: 5'd1, rs2a: 5'd2, rs3a: 5'd3,
          rs1d: pc + 1, rs2d: pc + 2, rs3d: pc + 3, rda: rda, rdd: rdd, rdh: rdh, wide: wide,
          maddr: pend ? 32'h100 : 32'h0, mwd: 32'h0, rmask: pend ? 4'hF : 4'h0, wmask: 4'h0,
          pending: pend};
    return t;
  endfunction

  function automatic vec_t mk(logic v, logic fl, logic rsp, logic pend, logic [31:0] pc, logic [31:0] pcw,
                              logic trap, logic [4:0] rda, logic [31:0] rdd, logic [31:0] rdh, logic wide,
                              logic [31:0] rdata, logic e_rdy, logic e_val, logic [63:0] e_ord,
                              logic e_intr, logic [31:0] e_rdd, logic [31:0] e_rdh, logic e_err);
    vec_t r;
    r.t = mk_txn(pc, pcw, trap, rda, rdd, rdh, wide, pend);
    r.v = v; r.fl = fl; r.rsp = rsp; r.rdata = rdata; r.e_rdy = e_rdy; r.e_val = e_val;
    r.e_ord = e_ord; r.e_intr = e_intr; r.e_rdd = e_rdd; r.e_rdh = e_rdh; r.e_err = e_err;
    return r;
  endfunction

  function automatic txn_t rnd_txn();
    txn_t t;
    t = '{insn: $urandom, pc_r: $urandom, pc_w: $urandom, trap: ($urandom_range(0, 7) == 0),
          rs1a: 5'($urandom), rs2a: 5'($urandom), rs3a: 5'($urandom),
          rs1d: $urandom, rs2d: $urandom, rs3d: $urandom,
          rda: ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), rdd: $urandom, rdh: $urandom,
          wide: 1'($urandom), maddr: $urandom, mwd: $urandom, rmask: 4'($urandom), wmask: 4'($urandom),
          pending: ($urandom_range(0, 2) == 0)};
    return t;
  endfunction

  vec_t vt[25];
  logic rdy;
  txn_t idle_t;

  initial begin
    idle_t = mk_txn(0, 0, 0, 0, 0, 0, 0, 0);
    vt[0]  = mk(1,0,0,0,'h0,'h4,0,1,1,0,0,0,             1,1,0,0,1,0,0);
    vt[1]  = mk(1,0,0,0,'h4,'h8,0,2,2,0,0,0,             1,1,1,0,2,0,0);
    vt[2]  = mk(1,0,0,0,'h8,'hc,0,3,3,0,0,0,             1,1,2,0,3,0,0);
    vt[3]  = mk(0,0,0,0,0,0,0,0,0,0,0,0,                 1,0,0,0,0,0,0);
    vt[4]  = mk(1,0,0,0,'hc,'h10,0,0,'hDEADBEEF,'h1234,1,0,  1,1,3,0,0,0,0);
    vt[5]  = mk(1,0,0,0,'h10,'h14,0,5,'hDEADBEEF,'h1234,1,0, 1,1,4,0,'hDEADBEEF,'h1234,0);
    vt[6]  = mk(1,0,0,1,'h14,'h18,0,6,0,0,0,0,           1,0,0,0,0,0,0);
    vt[7]  = mk(0,0,0,0,0,0,0,0,0,0,0,0,                 0,0,0,0,0,0,0);
    vt[8]  = mk(0,0,0,0,0,0,0,0,0,0,0,0,                 0,0,0,0,0,0,0);
    vt[9]  = mk(0,0,1,0,0,0,0,0,0,0,0,'hA5A5A5A5,        0,1,5,0,'hA5A5A5A5,0,0);
    vt[10] = mk(1,0,0,0,'h40,'h80,1,0,0,0,0,0,           1,1,6,0,0,0,0);
    vt[11] = mk(1,0,0,0,'h80,'h84,0,7,7,0,0,0,           1,1,7,1,7,0,0);
    vt[12] = mk(1,0,0,0,'h84,'h88,0,8,8,0,0,0,           1,1,8,0,8,0,0);
    vt[13] = mk(1,0,0,1,'h88,'h8c,0,9,0,0,0,0,           1,0,0,0,0,0,0);
    vt[14] = mk(0,1,0,0,0,0,0,0,0,0,0,0,                 0,0,0,0,0,0,0);
    vt[15] = mk(1,0,0,0,'h88,'h8c,0,9,9,0,0,0,           1,1,9,0,9,0,0);
    vt[16] = mk(1,0,0,1,'h8c,'h90,0,10,0,0,0,0,          1,0,0,0,0,0,0);
    vt[17] = mk(1,0,0,0,'h200,'h204,0,11,11,0,0,0,       0,0,0,0,0,0,1);
    vt[18] = mk(0,0,1,0,0,0,0,0,0,0,0,'h11112222,        0,1,10,0,'h11112222,0,1);
    vt[19] = mk(0,0,1,0,0,0,0,0,0,0,0,'h5,               1,0,0,0,0,0,1);
    vt[20] = mk(0,0,0,0,0,0,0,0,0,0,0,0,                 1,0,0,0,0,0,1);
    vt[21] = mk(1,0,0,0,'h300,'h80,1,1,1,0,0,0,          1,1,11,0,1,0,1);
    vt[22] = mk(1,0,0,0,'h80,'h80,1,2,2,0,0,0,           1,1,12,1,2,0,1);
    vt[23] = mk(1,0,0,0,'h80,'h84,0,3,3,0,0,0,           1,1,13,1,3,0,1);
    vt[24] = mk(1,0,0,0,'h84,'h88,0,4,4,0,0,0,           1,1,14,0,4,0,1);

    drive(idle_t, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge g_clk);
    chk("reset_valid", 64'(rvfi_valid), 64'(0));
    chk("reset_ready", 64'(trs_ready), 64'(1));
    chk("reset_err", 64'(trace_err), 64'(0));
    chk_rec("reset_record");
    g_resetn = 1'b1;

    foreach (vt[i]) begin
      cyc(vt[i].t, vt[i].v, vt[i].fl, vt[i].rsp, vt[i].rdata, rdy);
      chk($sformatf("tbl%0d_ready", i), 64'(rdy), 64'(vt[i].e_rdy));
      chk($sformatf("tbl%0d_valid", i), 64'(rvfi_valid), 64'(vt[i].e_val));
      chk($sformatf("tbl%0d_err", i), 64'(trace_err), 64'(vt[i].e_err));
      if (vt[i].e_val) begin
        chk($sformatf("tbl%0d_order", i), rvfi_order, vt[i].e_ord);
        chk($sformatf("tbl%0d_intr", i), 64'(rvfi_intr), 64'(vt[i].e_intr));
        chk($sformatf("tbl%0d_rd_wdata", i), 64'(rvfi_rd_wdata), 64'(vt[i].e_rdd));
        chk($sformatf("tbl%0d_rd_wdatahi", i), 64'(rvfi_rd_wdatahi), 64'(vt[i].e_rdh));
        if (vt[i].rsp) begin
          chk($sformatf("tbl%0d_mem_rdata", i), 64'(rvfi_mem_rdata), 64'(vt[i].e_rdd));
          chk($sformatf("tbl%0d_rmask", i), 64'(rvfi_mem_rmask), 64'hF);
        end
      end
    end

    cyc(mk_txn('h500, 'h504, 0, 12, 0, 0, 0, 1), 1, 0, 0, 0, rdy);
    @(negedge g_clk);
    drive(idle_t, 0, 0, 0, 0);
    #2 g_resetn = 1'b0;
    model_reset();
    #1;
    chk("async_rst_valid", 64'(rvfi_valid), 64'(0));
    chk("async_rst_ready", 64'(trs_ready), 64'(1));
    chk("async_rst_err", 64'(trace_err), 64'(0));
    chk_rec("async_rst_record");
    @(negedge g_clk);
    g_resetn = 1'b1;
    cyc(mk_txn('h600, 'h604, 0, 13, 'h77, 0, 0, 0), 1, 0, 0, 0, rdy);
    chk("post_rst_order", rvfi_order, 64'(0));
    chk("post_rst_valid", 64'(rvfi_valid), 64'(1));
    cyc(idle_t, 0, 0, 0, 0, rdy);
    chk("post_rst_no_stale", 64'(rvfi_valid), 64'(0));

    for (int n = 0; n < 600; n++) begin
      bit busy = held_q.size() != 0;
      logic v = $urandom_range(0, 99) < 55;
      logic fl = $urandom_range(0, 99) < 5;
      logic rsp = busy ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 2);
      cyc(rnd_txn(), v, fl, rsp, $urandom, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/xc_rvfi_trace_gen.md
Name: xc_rvfi_trace_gen

Overview:
Core-side producer of the XCFI/RVFI retirement trace consumed by the per-instruction spec models and the formal checker. It collects retirement data from the writeback stage and merges late load data from the memory response. It then emits exactly one registered trace record per retired instruction, with order numbering, interrupt marking and rd-zero masking. It is instantiated inside the core top only when the formal/trace build flag is set.

Parameters:
XLEN, 32, architectural register width.
ORDER_W, 64, width of the retirement order counter.

Ports:
g_clk  in  1  core clock
g_resetn  in  1  asynchronous active-low reset
trs_valid  in  1  writeback retires an instruction this cycle
trs_ready  out  1  block can accept a retirement (low only while holding for load data)
trs_flush  in  1  pipeline flush; discards a held record
trs_insn  in  32  retired instruction word
trs_pc_rdata / trs_pc_wdata  in  XLEN each  pc of the instruction, next pc
trs_trap  in  1  instruction trapped
trs_rs1_addr / trs_rs2_addr / trs_rs3_addr  in  5 each  source register indexes
trs_rs1_rdata / trs_rs2_rdata / trs_rs3_rdata  in  XLEN each  source register values
trs_rd_addr  in  5  destination register index
trs_rd_wdata / trs_rd_wdatahi  in  XLEN each  destination data, high half
trs_rd_wide  in  1  wide (register pair) write
trs_mem_addr / trs_mem_wdata  in  XLEN each  data address, store data
trs_mem_rmask / trs_mem_wmask  in  4 each  byte masks
trs_mem_pending  in  1  load data not yet available
mem_rsp_valid  in  1  load response this cycle
mem_rsp_rdata  in  XLEN  load data, written to rd and mem_rdata
rvfi_valid  out  1  record valid (one-cycle pulse)
rvfi_order  out  ORDER_W  retirement index
rvfi_insn  out  32  instruction word
rvfi_trap / rvfi_intr / rvfi_halt  out  1 each  trap, first insn of handler, halt (tied 0)
rvfi_rs1_addr / rvfi_rs2_addr / rvfi_rs3_addr  out  5 each  source indexes
rvfi_rs1_rdata / rvfi_rs2_rdata / rvfi_rs3_rdata  out  XLEN each  source values
rvfi_rd_addr  out  5  destination index
rvfi_rd_wdata / rvfi_rd_wdatahi  out  XLEN each  destination data
rvfi_rd_wide  out  1  wide write
rvfi_pc_rdata / rvfi_pc_wdata  out  XLEN each  pc values
rvfi_mem_addr / rvfi_mem_rdata / rvfi_mem_wdata  out  XLEN each  memory fields
rvfi_mem_rmask / rvfi_mem_wmask  out  4 each  byte masks
trace_err  out  1  sticky protocol violation

Behaviour:
- Reset: all rvfi_* outputs 0, order counter 0, intr_pending 0, trace_err 0, state IDLE, trs_ready 1.
- FSM states: IDLE, HOLD.
- IDLE, trs_valid and !trs_mem_pending:
  - Record is registered; rvfi_valid is high the next cycle (latency 1).
  - rvfi_order takes the current counter value; the counter then increments, wrapping at 2^ORDER_W.
- IDLE, trs_valid and trs_mem_pending:
  - All fields are captured and the FSM moves to HOLD; trs_ready is 0 while in HOLD.
- HOLD, mem_rsp_valid:
  - mem_rsp_rdata is written into rvfi_mem_rdata and rvfi_rd_wdata.
  - The record is emitted the next cycle and the FSM returns to IDLE.
- A response arriving in the same cycle as the pending retirement is not merged: it is ignored and trace_err is set.
- mem_rsp_valid in IDLE is a violation: sets trace_err, no emission.
- trs_valid while in HOLD is a violation: sets trace_err, the input is dropped, the held record is kept.
- trs_flush:
  - In HOLD, discards the record, returns to IDLE and leaves the order counter unchanged.
  - In IDLE, trs_flush with trs_valid in the same cycle: the flush wins and nothing is emitted.
  - Otherwise trs_flush has no effect.
- rd masking: if rd_addr == 0, rvfi_rd_wdata and rvfi_rd_wdatahi are forced to 0. rvfi_rd_wdatahi is also 0 whenever rd_wide is 0.
- Interrupt marking:
  - An emitted record with trap=1 sets intr_pending.
  - The next emitted record carries rvfi_intr=1 and clears intr_pending.
  - A trap record that immediately follows another trap record carries intr=1 and sets intr_pending again.
- rvfi_valid is deasserted in every cycle with no emission. Data outputs hold their last values.
- Asynchronous reset mid-HOLD drops the held record and clears all state.

Test Plan:
- After reset, three back-to-back ALU retirements (pc 0x0, 0x4, 0x8) -> rvfi_valid for three consecutive cycles, order 0, 1, 2, each one cycle after its trs_valid.
- Retirement with rd_addr=0, rd_wdata=0xDEADBEEF, rd_wide=1, wdatahi=0x1234 -> rvfi_rd_wdata=0 and rvfi_rd_wdatahi=0; same with rd_addr=5 -> 0xDEADBEEF and 0x1234.
- Load at addr 0x100 with pending=1, mem_rsp_valid 3 cycles later carrying 0xA5A5A5A5 -> trs_ready low for 3 cycles; one record with mem_rdata = rd_wdata = 0xA5A5A5A5, rmask 0xF, emitted one cycle after the response.
- Trap record (pc_wdata=0x80) followed by a retirement at pc 0x80 -> first record trap=1, intr=0; second record intr=1; third record intr=0.
- Pending load, then trs_flush in HOLD, then a new retirement -> no record for the flushed load; new record's order equals the flushed load's would-be order; trace_err stays 0.
- trs_valid asserted in HOLD, then a later mem_rsp_valid in IDLE -> trace_err rises on the first violation and stays 1 until reset; the held record is still emitted correctly.
